// File: rtl/vortex_mem_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vortex_mem_seq_pkg : shared types and constants for the line-to-word sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package vortex_mem_seq_pkg;

    localparam int BEATS      = 16;
    localparam int BEAT_W     = 4;
    localparam int LINE_OFS_W = 6;   // log2 of bytes per cache line

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Byte address of one 32b beat inside a line; wraps silently at 32 bits.
    function automatic logic [31:0] beat_addr(input logic [31:0]       base,
                                              input logic [31:0]       line_addr,
                                              input logic [BEAT_W-1:0] beat);
        return base + (line_addr << LINE_OFS_W) + (32'(beat) << 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vortex_mem_req_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vx_mem_if / vx_bus_if : Vortex line channel and 32b generic bus channel
// Rev 1.0
// ----------------------------------------------------------------------------
interface vx_mem_if #(
    parameter int LINE_W  = 512,
    parameter int LADDR_W = 26,
    parameter int TAG_W   = 56
) ();
    logic                  mem_req_valid;
    logic                  mem_req_rw;
    logic [LINE_W/8-1:0]   mem_req_byteen;
    logic [LADDR_W-1:0]    mem_req_addr;
    logic [LINE_W-1:0]     mem_req_data;
    logic [TAG_W-1:0]      mem_req_tag;
    logic                  mem_req_ready;
    logic                  mem_rsp_valid;
    logic [LINE_W-1:0]     mem_rsp_data;
    logic [TAG_W-1:0]      mem_rsp_tag;
    logic                  mem_rsp_ready;

    // master = Vortex core side, slave = sequencer
    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );
    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );
endinterface

interface vx_bus_if #(
    parameter int BUS_W = 32
) ();
    logic               bus_wen;
    logic               bus_ren;
    logic [31:0]        bus_addr;
    logic [BUS_W-1:0]   bus_wdata;
    logic [BUS_W/8-1:0] bus_strobe;
    logic [BUS_W-1:0]   bus_rdata;
    logic               bus_request_stall;
    logic               bus_error;

    // master = sequencer, slave = AHB manager front end
    modport master (
        output bus_wen, bus_ren, bus_addr, bus_wdata, bus_strobe,
        input  bus_rdata, bus_request_stall, bus_error
    );
    modport slave (
        input  bus_wen, bus_ren, bus_addr, bus_wdata, bus_strobe,
        output bus_rdata, bus_request_stall, bus_error
    );
endinterface
`default_nettype wire

// File: rtl/vortex_mem_req_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vortex_mem_req_sequencer : splits Vortex line requests into 32b bus beats
// Rev 1.0
// ----------------------------------------------------------------------------
module vortex_mem_req_sequencer
    import vortex_mem_seq_pkg::*;
#(
    parameter int          LINE_W    = 512,
    parameter int          LADDR_W   = 26,
    parameter int          TAG_W     = 56,
    parameter int          BUS_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  wire logic clk,
    input  wire logic reset,
    vx_mem_if.slave   mem,
    vx_bus_if.master  bus,
    output logic      busy,
    output logic      err_sticky,
    input  wire logic err_clear
);

    localparam int STRB_W = BUS_W / 8;

    state_t                state_q,  state_d;
    logic [BEAT_W-1:0]     beat_q,   beat_d;
    logic                  err_q,    err_d;
    logic [LINE_W/8-1:0]   byteen_q, byteen_d;
    logic [LADDR_W-1:0]    addr_q,   addr_d;
    logic [LINE_W-1:0]     line_q,   line_d;
    logic [TAG_W-1:0]      tag_q,    tag_d;

    logic                  wr_found;
    logic                  wr_more;
    logic [BEAT_W-1:0]     wr_beat;
    logic [BEAT_W-1:0]     cur_beat;
    logic                  accept;
    logic                  beat_done;
    logic                  wen;
    logic                  ren;

    // Lowest enabled write beat at or after beat_q, and whether another follows it.
    always_comb begin
        wr_found = 1'b0;
        wr_beat  = '0;
        wr_more  = 1'b0;
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (BEAT_W'(i) >= beat_q && byteen_q[i*STRB_W +: STRB_W] != '0) begin
                wr_found = 1'b1;
                wr_beat  = BEAT_W'(i);
            end
        end
        for (int i = 0; i < BEATS; i++) begin
            if (wr_found && BEAT_W'(i) > wr_beat && byteen_q[i*STRB_W +: STRB_W] != '0) begin
                wr_more = 1'b1;
            end
        end
    end

    assign wen      = (state_q == ST_WRITE) && wr_found;
    assign ren      = (state_q == ST_READ);
    assign cur_beat = (state_q == ST_WRITE) ? wr_beat : beat_q;
    assign accept   = mem.mem_req_valid && (state_q == ST_IDLE);

    assign bus.bus_wen    = wen;
    assign bus.bus_ren    = ren;
    assign bus.bus_addr   = (wen || ren) ? beat_addr(BASE_ADDR, 32'(addr_q), cur_beat) : '0;
    assign bus.bus_wdata  = wen ? line_q[cur_beat*BUS_W +: BUS_W] : '0;
    assign bus.bus_strobe = wen ? byteen_q[cur_beat*STRB_W +: STRB_W] : '0;

    assign mem.mem_req_ready = (state_q == ST_IDLE);
    assign mem.mem_rsp_valid = (state_q == ST_RESP);
    assign mem.mem_rsp_data  = (state_q == ST_RESP) ? line_q : '0;
    assign mem.mem_rsp_tag   = (state_q == ST_RESP) ? tag_q  : '0;

    assign busy       = (state_q != ST_IDLE);
    assign err_sticky = err_q;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        byteen_d  = byteen_q;
        addr_d    = addr_q;
        line_d    = line_q;
        tag_d     = tag_q;
        beat_done = (wen || ren) && !bus.bus_request_stall;
        // A new error outranks a simultaneous clear.
        err_d     = (err_q && !err_clear) || (beat_done && bus.bus_error);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    byteen_d = mem.mem_req_byteen;
                    addr_d   = mem.mem_req_addr;
                    line_d   = mem.mem_req_data;
                    tag_d    = mem.mem_req_tag;
                    beat_d   = '0;
                    state_d  = mem.mem_req_rw ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (!wr_found) begin
                    state_d = ST_IDLE;
                end else if (beat_done) begin
                    if (wr_more) beat_d = wr_beat + 1'b1;
                    else         state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (beat_done) begin
                    line_d[beat_q*BUS_W +: BUS_W] = bus.bus_rdata;
                    if (beat_q == BEAT_W'(BEATS - 1)) state_d = ST_RESP;
                    else                              beat_d  = beat_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (mem.mem_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Request/line storage carries no reset; it is only read outside IDLE.
    always_ff @(posedge clk) begin
        byteen_q <= byteen_d;
        addr_q   <= addr_d;
        line_q   <= line_d;
        tag_q    <= tag_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_vortex_mem_req_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vortex_mem_req_sequencer : scoreboard bench for the line-to-word sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vortex_mem_req_sequencer;
    import vortex_mem_seq_pkg::*;

    localparam int          LINE_W  = 512;
    localparam int          LADDR_W = 26;
    localparam int          TAG_W   = 56;
    localparam int          BUS_W   = 32;
    localparam logic [31:0] BASE    = 32'h8000_0000;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    logic err_clear;
    logic busy;
    logic err_sticky;
    logic stall;
    logic berr;
    logic [31:0] rd_xor;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int rsp_first_cyc = 0;
    int wen_cycles = 0;
    int rsp_valid_cycles = 0;
    int rsp_count = 0;
    logic rsp_valid_prev = 1'b0;

    beat_t exp_beats[$];
    rsp_t  exp_rsps[$];

    vx_mem_if #(.LINE_W(LINE_W), .LADDR_W(LADDR_W), .TAG_W(TAG_W)) mem ();
    vx_bus_if #(.BUS_W(BUS_W)) bus ();

    vortex_mem_req_sequencer #(
        .LINE_W(LINE_W), .LADDR_W(LADDR_W), .TAG_W(TAG_W), .BUS_W(BUS_W), .BASE_ADDR(BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (mem),
        .bus        (bus),
        .busy       (busy),
        .err_sticky (err_sticky),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;

    // Bus slave: read word is the beat index (address bits 5:2) xor a per-test pattern.
    assign bus.bus_rdata         = rd_xor ^ {28'd0, bus.bus_addr[5:2]};
    assign bus.bus_request_stall = stall;
    assign bus.bus_error         = berr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem.mem_req_valid && mem.mem_req_ready) accept_cyc = cyc;
            if (bus.bus_wen) wen_cycles++;
            if (mem.mem_rsp_valid) rsp_valid_cycles++;
            if (mem.mem_rsp_valid && !rsp_valid_prev) rsp_first_cyc = cyc;
            if ((bus.bus_wen || bus.bus_ren) && !bus.bus_request_stall) begin
                check("beat_expected", LINE_W'(exp_beats.size() != 0), LINE_W'(1));
                if (exp_beats.size() != 0) begin
                    beat_t e;
                    e = exp_beats.pop_front();
                    check("beat_kind", LINE_W'(bus.bus_wen), LINE_W'(e.wr));
                    check("beat_addr", LINE_W'(bus.bus_addr), LINE_W'(e.addr));
                    if (e.wr) begin
                        check("beat_wdata", LINE_W'(bus.bus_wdata), LINE_W'(e.wdata));
                        check("beat_strobe", LINE_W'(bus.bus_strobe), LINE_W'(e.strb));
                    end
                end
            end
            if (mem.mem_rsp_valid && mem.mem_rsp_ready) begin
                rsp_count++;
                check("rsp_expected", LINE_W'(exp_rsps.size() != 0), LINE_W'(1));
                if (exp_rsps.size() != 0) begin
                    rsp_t r;
                    r = exp_rsps.pop_front();
                    check("rsp_data", mem.mem_rsp_data, r.data);
                    check("rsp_tag", LINE_W'(mem.mem_rsp_tag), LINE_W'(r.tag));
                end
            end
        end
        rsp_valid_prev = mem.mem_rsp_valid && !reset;
    end

    function automatic logic [LINE_W-1:0] read_line(input logic [31:0] x);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < BEATS; i++) l[i*32 +: 32] = x ^ 32'(i);
        return l;
    endfunction

    task automatic issue(input logic rw, input logic [63:0] be, input logic [25:0] a,
                         input logic [LINE_W-1:0] d, input logic [TAG_W-1:0] t);
        bit ok;
        for (int i = 0; i < BEATS; i++) begin
            beat_t b;
            b.wr    = rw;
            b.addr  = BASE + (32'(a) << 6) + 32'(i * 4);
            b.wdata = d[i*32 +: 32];
            b.strb  = be[i*4 +: 4];
            if (!rw || b.strb != 4'h0) exp_beats.push_back(b);
        end
        if (!rw) exp_rsps.push_back('{data: read_line(rd_xor), tag: t});
        @(posedge clk); #1;
        mem.mem_req_valid  = 1'b1;
        mem.mem_req_rw     = rw;
        mem.mem_req_byteen = be;
        mem.mem_req_addr   = a;
        mem.mem_req_data   = d;
        mem.mem_req_tag    = t;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (mem.mem_req_ready) ok = 1'b1;
        end
        check("req_accepted", LINE_W'(ok), LINE_W'(1));
        @(posedge clk); #1;
        mem.mem_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (mem.mem_req_ready) ok = 1'b1;
        end
        check("reach_idle", LINE_W'(ok), LINE_W'(1));
    endtask

    task automatic wait_addr(input logic [31:0] a);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk); #1;
            if ((bus.bus_ren || bus.bus_wen) && bus.bus_addr == a) ok = 1'b1;
        end
        check("beat_seen", LINE_W'(ok), LINE_W'(1));
    endtask

    initial begin
        logic [LINE_W-1:0] wd;
        logic [63:0]       be;
        int                w0;
        int                v0;

        reset = 1'b1; err_clear = 1'b0; stall = 1'b0; berr = 1'b0; rd_xor = '0;
        mem.mem_req_valid = 1'b0; mem.mem_req_rw = 1'b0; mem.mem_req_byteen = '0;
        mem.mem_req_addr = '0; mem.mem_req_data = '0; mem.mem_req_tag = '0;
        mem.mem_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", LINE_W'(mem.mem_req_ready), LINE_W'(1));
        check("rst_rsp_valid", LINE_W'(mem.mem_rsp_valid), LINE_W'(0));
        check("rst_wen_ren",   LINE_W'({bus.bus_wen, bus.bus_ren}), LINE_W'(0));
        check("rst_bus_addr",  LINE_W'(bus.bus_addr), LINE_W'(0));
        check("rst_busy_err",  LINE_W'({busy, err_sticky}), LINE_W'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Plain read, data word i = i
        issue(1'b0, '0, 26'h10, '0, 56'h00_1234_5678_9ABC);
        wait_idle();
        check("rd_latency", LINE_W'(rsp_first_cyc - accept_cyc), LINE_W'(17));

        // Read with 3 stall cycles on beat 5
        rd_xor = 32'h5A5A_0000;
        issue(1'b0, '0, 26'h20, '0, 56'hAB_CDEF_0011_2233);
        wait_addr(BASE + 32'h0814);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_hold_addr", LINE_W'(bus.bus_addr), LINE_W'(BASE + 32'h0814));
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall_hold_addr", LINE_W'(bus.bus_addr), LINE_W'(BASE + 32'h0814));
        wait_idle();
        check("stall_rd_latency", LINE_W'(rsp_first_cyc - accept_cyc), LINE_W'(20));

        // Sparse write: beats 0 and 3 only
        for (int i = 0; i < BEATS; i++) wd[i*32 +: 32] = $urandom;
        w0 = wen_cycles; v0 = rsp_valid_cycles;
        issue(1'b1, 64'h0000_0000_0000_F00F, 26'h3, wd, 56'h77);
        wait_idle();
        check("sparse_wen_cycles", LINE_W'(wen_cycles - w0), LINE_W'(2));
        check("write_no_rsp", LINE_W'(rsp_valid_cycles - v0), LINE_W'(0));

        // Partial strobes on beats 7 and 15
        for (int i = 0; i < BEATS; i++) wd[i*32 +: 32] = $urandom;
        be = '0; be[7*4 +: 4] = 4'h8; be[15*4 +: 4] = 4'h3;
        w0 = wen_cycles;
        issue(1'b1, be, 26'h3FF_FFFF, wd, 56'h78);
        wait_idle();
        check("edge_wen_cycles", LINE_W'(wen_cycles - w0), LINE_W'(2));

        // All-zero byte enables: no bus traffic, ready again 2 cycles after accept
        w0 = wen_cycles;
        issue(1'b1, '0, 26'h5, wd, 56'h79);
        @(negedge clk);
        check("zero_be_busy_c1", LINE_W'(mem.mem_req_ready), LINE_W'(0));
        @(negedge clk);
        check("zero_be_ready_c2", LINE_W'(mem.mem_req_ready), LINE_W'(1));
        check("zero_be_wen", LINE_W'(wen_cycles - w0), LINE_W'(0));

        // Response backpressure and bus error on beat 2
        rd_xor = 32'hDEAD_BEEF;
        mem.mem_rsp_ready = 1'b0;
        issue(1'b0, '0, 26'h40, '0, 56'hFE_DCBA_9876_5432);
        wait_addr(BASE + 32'h1008);
        berr = 1'b1;
        @(posedge clk); #1;
        berr = 1'b0;
        begin
            bit ok;
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                @(posedge clk); #1;
                if (mem.mem_rsp_valid) ok = 1'b1;
            end
            check("rsp_seen", LINE_W'(ok), LINE_W'(1));
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_rsp_valid", LINE_W'(mem.mem_rsp_valid), LINE_W'(1));
            check("hold_rsp_data",  mem.mem_rsp_data, read_line(32'hDEAD_BEEF));
            check("hold_rsp_tag",   LINE_W'(mem.mem_rsp_tag), LINE_W'(56'hFE_DCBA_9876_5432));
            check("hold_req_ready", LINE_W'(mem.mem_req_ready), LINE_W'(0));
            check("hold_err_sticky", LINE_W'(err_sticky), LINE_W'(1));
        end
        @(posedge clk); #1;
        mem.mem_rsp_ready = 1'b1;
        wait_idle();
        check("err_sticky_kept", LINE_W'(err_sticky), LINE_W'(1));
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(negedge clk);
        check("err_cleared", LINE_W'(err_sticky), LINE_W'(0));

        // Reset while reading beat 8 abandons the request
        rd_xor = 32'h0F0F_0F0F;
        v0 = rsp_count;
        issue(1'b0, '0, 26'h80, '0, 56'h11);
        wait_addr(BASE + 32'h2020);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_beats.delete();
        exp_rsps.delete();
        @(negedge clk);
        check("rst_mid_ren", LINE_W'(bus.bus_ren), LINE_W'(0));
        check("rst_mid_ready", LINE_W'({mem.mem_req_ready, busy}), LINE_W'(2'b10));
        repeat (20) @(negedge clk);
        check("rst_mid_no_rsp", LINE_W'(rsp_count - v0), LINE_W'(0));

        // Fresh read; error and clear in the same cycle leaves the flag set
        rd_xor = 32'h1357_9BDF;
        issue(1'b0, '0, 26'h81, '0, 56'h22);
        wait_addr(BASE + 32'h204C);
        berr = 1'b1; err_clear = 1'b1;
        @(posedge clk); #1;
        berr = 1'b0; err_clear = 1'b0;
        @(negedge clk);
        check("err_set_wins", LINE_W'(err_sticky), LINE_W'(1));
        wait_idle();
        check("fresh_rd_latency", LINE_W'(rsp_first_cyc - accept_cyc), LINE_W'(17));

        check("beats_drained", LINE_W'(exp_beats.size()), LINE_W'(0));
        check("rsps_drained",  LINE_W'(exp_rsps.size()), LINE_W'(0));
        check("rsp_total",     LINE_W'(rsp_count), LINE_W'(4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
